// File: rtl/mem_read_streamer.sv
// Read-only memory master that fetches a run of consecutive words with a req/ack
// handshake and forwards them through a small FIFO as a valid/ready stream.
module mem_read_streamer #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  count,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  mem_w_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, REQ, DRAIN, ERROR} state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  remaining_q;
  logic [TMO_W-1:0]      req_cycles_q;

  logic                  load;
  logic                  zero_done;
  logic                  issue;
  logic                  accept;
  logic                  timeout;
  logic                  finish;
  logic                  flush;
  logic                  last_word;
  logic                  pop;

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic                  fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [OCC_W-1:0]      occ;

  assign mem_w_en  = 1'b0;
  assign last_word = (remaining_q == CNT_WIDTH'(1));
  assign out_valid = (occ != '0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_last  = out_valid & fifo_last[rd_ptr];
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An ack in the very first REQ cycle is a protocol violation and is dropped;
  // a late ack wins over a timeout landing in the same cycle.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    zero_done = 1'b0;
    issue     = 1'b0;
    accept    = 1'b0;
    timeout   = 1'b0;
    finish    = 1'b0;
    flush     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            load    = 1'b1;
            state_d = ISSUE;
          end else begin
            zero_done = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (occ < OCC_W'(FIFO_DEPTH)) begin
          issue   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ack && (req_cycles_q != '0)) begin
          accept  = 1'b1;
          state_d = last_word ? DRAIN : ISSUE;
        end else if (req_cycles_q == TMO_W'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = ERROR;
        end
      end
      DRAIN: begin
        if (occ == '0) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      ERROR: begin
        flush   = 1'b1;
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q       <= '0;
      remaining_q  <= '0;
      req_cycles_q <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done <= zero_done | finish;
      if (load) begin
        addr_q      <= base_addr;
        remaining_q <= count;
        err         <= 1'b0;
        busy        <= 1'b1;
      end
      if (issue) begin
        mem_req      <= 1'b1;
        mem_addr     <= addr_q;
        req_cycles_q <= '0;
      end
      if ((state_q == REQ) && !accept && !timeout) begin
        req_cycles_q <= req_cycles_q + TMO_W'(1);
      end
      if (accept) begin
        mem_req     <= 1'b0;
        addr_q      <= addr_q + ADDR_WIDTH'(1);
        remaining_q <= remaining_q - CNT_WIDTH'(1);
      end
      if (timeout) begin
        mem_req <= 1'b0;
        err     <= 1'b1;
      end
      if (finish) begin
        busy <= 1'b0;
      end
    end
  end

  // Output FIFO bookkeeping; the ISSUE space check means a push never finds it full.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({accept, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_data[wr_ptr] <= mem_data;
      fifo_last[wr_ptr] <= last_word;
    end
  end

endmodule

// File: tb/tb_mem_read_streamer.sv
// Directed bench for mem_read_streamer: a delay-programmable ack responder plus
// per-cycle protocol checks, driven from one linear initial block.
module tb_mem_read_streamer;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  base_addr = '0;
  logic [7:0]   count = '0;
  logic         busy;
  logic         done;
  logic         err;
  logic         mem_req;
  logic         mem_ack;
  logic         mem_w_en;
  logic [15:0]  mem_addr;
  wire  [255:0] mem_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [255:0] out_data;
  logic         out_last;

  logic         slave_ack = 1'b0;
  logic         manual_ack = 1'b0;
  int           ack_delay = 2;
  int           req_age = 0;

  int           checks = 0;
  int           errors = 0;
  logic [15:0]  req_addrs [$];
  logic [255:0] beat_data [$];
  logic         beat_last [$];
  int           done_pulses = 0;
  int           req_high_cycles = 0;
  logic         prev_req = 1'b0;
  logic         prev_ack = 1'b0;
  logic [15:0]  prev_addr = '0;
  int           saved_reqs;

  mem_read_streamer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_w_en  (mem_w_en),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  function automatic logic [255:0] mem_word(input logic [15:0] a);
    return {16{a ^ 16'hC3C3}};
  endfunction

  assign mem_data = mem_word(mem_addr);
  assign mem_ack  = slave_ack | manual_ack;

  always #5 clk = ~clk;

  // Memory responder: acks ack_delay cycles after mem_req rises, never when ack_delay is 0.
  always @(posedge clk) begin
    if (!reset_n || !mem_req) begin
      req_age   <= 0;
      slave_ack <= 1'b0;
    end else begin
      req_age   <= req_age + 1;
      slave_ack <= (ack_delay != 0) && (req_age + 1 == ack_delay);
    end
  end

  task automatic check_output(input string tag, input logic [255:0] observed,
                              input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock: log the beat about to transfer, then observe just after the edge.
  task automatic step();
    logic         pre_valid;
    logic         pre_ready;
    logic         pre_rst;
    logic [255:0] pre_data;
    pre_valid = out_valid;
    pre_ready = out_ready;
    pre_rst   = reset_n;
    pre_data  = out_data;
    if (reset_n && out_valid && out_ready) begin
      beat_data.push_back(out_data);
      beat_last.push_back(out_last);
    end
    @(posedge clk);
    #1;
    if (mem_req) req_high_cycles++;
    if (mem_req && !prev_req) req_addrs.push_back(mem_addr);
    if (done) done_pulses++;
    check_output("w_en_zero", 256'(mem_w_en), 256'(0));
    if (mem_ack) begin
      check_output("ack_with_req", 256'(mem_req), 256'(1));
      check_output("ack_is_pulse", 256'(prev_ack), 256'(0));
    end
    if (pre_rst && pre_valid && !pre_ready) begin
      check_output("hold_valid", 256'(out_valid), 256'(1));
      check_output("hold_data", out_data, pre_data);
    end
    if (pre_rst && prev_req && mem_req) begin
      check_output("req_addr_stable", 256'(mem_addr), 256'(prev_addr));
    end
    prev_req  = mem_req;
    prev_ack  = mem_ack;
    prev_addr = mem_addr;
  endtask

  task automatic apply_stimulus(input logic [15:0] b, input logic [7:0] c);
    base_addr = b;
    count     = c;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic clear_log();
    req_addrs.delete();
    beat_data.delete();
    beat_last.delete();
    done_pulses     = 0;
    req_high_cycles = 0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      step();
      if (done) seen = 1'b1;
    end
    check_output({tag, "_done_seen"}, 256'(seen), 256'(1));
    step();
    step();
  endtask

  task automatic check_stream(input string tag, input logic [15:0] b, input int n);
    check_output({tag, "_req_count"}, 256'(req_addrs.size()), 256'(n));
    check_output({tag, "_beat_count"}, 256'(beat_data.size()), 256'(n));
    for (int i = 0; i < n && i < req_addrs.size(); i++) begin
      check_output({tag, "_addr"}, 256'(req_addrs[i]), 256'(16'(b + 16'(i))));
    end
    for (int i = 0; i < n && i < beat_data.size(); i++) begin
      check_output({tag, "_data"}, beat_data[i], mem_word(16'(b + 16'(i))));
      check_output({tag, "_last"}, 256'(beat_last[i]), 256'(i == n - 1));
    end
  endtask

  initial begin
    step();
    step();
    check_output("rst_busy", 256'(busy), 256'(0));
    check_output("rst_done", 256'(done), 256'(0));
    check_output("rst_err", 256'(err), 256'(0));
    check_output("rst_req", 256'(mem_req), 256'(0));
    check_output("rst_addr", 256'(mem_addr), 256'(0));
    check_output("rst_valid", 256'(out_valid), 256'(0));
    check_output("rst_last", 256'(out_last), 256'(0));
    reset_n = 1'b1;
    step();

    $display("[TB] basic transfer");
    clear_log();
    apply_stimulus(16'h0010, 8'd3);
    check_output("basic_busy", 256'(busy), 256'(1));
    wait_done("basic", 100);
    check_stream("basic", 16'h0010, 3);
    check_output("basic_done_pulses", 256'(done_pulses), 256'(1));
    check_output("basic_err", 256'(err), 256'(0));
    check_output("basic_busy_end", 256'(busy), 256'(0));

    $display("[TB] back-pressure");
    clear_log();
    out_ready = 1'b0;
    apply_stimulus(16'h0100, 8'd8);
    for (int i = 0; i < 40; i++) step();
    check_output("bp_req_held", 256'(req_addrs.size()), 256'(4));
    check_output("bp_req_low", 256'(mem_req), 256'(0));
    check_output("bp_valid", 256'(out_valid), 256'(1));
    check_output("bp_head", out_data, mem_word(16'h0100));
    check_output("bp_head_last", 256'(out_last), 256'(0));
    check_output("bp_busy", 256'(busy), 256'(1));
    out_ready = 1'b1;
    wait_done("bp", 300);
    check_stream("bp", 16'h0100, 8);
    check_output("bp_done_pulses", 256'(done_pulses), 256'(1));

    $display("[TB] address wrap");
    clear_log();
    apply_stimulus(16'hFFFE, 8'd4);
    wait_done("wrap", 200);
    check_stream("wrap", 16'hFFFE, 4);

    $display("[TB] ack timeout");
    clear_log();
    ack_delay = 0;
    apply_stimulus(16'h0200, 8'd2);
    wait_done("tmo", 200);
    check_output("tmo_req_cycles", 256'(req_high_cycles), 256'(64));
    check_output("tmo_req_count", 256'(req_addrs.size()), 256'(1));
    check_output("tmo_err", 256'(err), 256'(1));
    check_output("tmo_busy", 256'(busy), 256'(0));
    check_output("tmo_fifo_empty", 256'(out_valid), 256'(0));
    check_output("tmo_done_pulses", 256'(done_pulses), 256'(1));
    step();
    check_output("tmo_err_sticky", 256'(err), 256'(1));

    $display("[TB] zero count");
    clear_log();
    apply_stimulus(16'h0300, 8'd0);
    check_output("zero_done", 256'(done), 256'(1));
    check_output("zero_busy", 256'(busy), 256'(0));
    step();
    check_output("zero_done_off", 256'(done), 256'(0));
    check_output("zero_no_req", 256'(req_addrs.size()), 256'(0));
    check_output("zero_done_pulses", 256'(done_pulses), 256'(1));

    $display("[TB] early ack");
    clear_log();
    ack_delay = 3;
    apply_stimulus(16'h0400, 8'd1);
    check_output("early_err_cleared", 256'(err), 256'(0));
    for (int i = 0; i < 10 && !mem_req; i++) step();
    manual_ack = 1'b1;
    step();
    manual_ack = 1'b0;
    check_output("early_req_held", 256'(mem_req), 256'(1));
    check_output("early_addr", 256'(mem_addr), 256'(16'h0400));
    check_output("early_no_beat", 256'(out_valid), 256'(0));
    wait_done("early", 100);
    check_stream("early", 16'h0400, 1);
    check_output("early_done_pulses", 256'(done_pulses), 256'(1));

    $display("[TB] start while busy");
    clear_log();
    ack_delay = 2;
    apply_stimulus(16'h0500, 8'd2);
    step();
    step();
    step();
    apply_stimulus(16'h0600, 8'd5);
    wait_done("busy_start", 100);
    check_stream("busy_start", 16'h0500, 2);
    check_output("busy_start_done_pulses", 256'(done_pulses), 256'(1));

    $display("[TB] reset mid-transfer");
    clear_log();
    out_ready = 1'b0;
    apply_stimulus(16'h0700, 8'd6);
    for (int i = 0; i < 12; i++) step();
    check_output("mid_valid_before", 256'(out_valid), 256'(1));
    saved_reqs = req_addrs.size();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_output("mid_req", 256'(mem_req), 256'(0));
    check_output("mid_addr", 256'(mem_addr), 256'(0));
    check_output("mid_busy", 256'(busy), 256'(0));
    check_output("mid_done", 256'(done), 256'(0));
    check_output("mid_err", 256'(err), 256'(0));
    check_output("mid_valid", 256'(out_valid), 256'(0));
    check_output("mid_last", 256'(out_last), 256'(0));
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check_output("mid_no_done", 256'(done_pulses), 256'(0));
    check_output("mid_no_new_req", 256'(req_addrs.size()), 256'(saved_reqs));
    check_output("mid_idle_busy", 256'(busy), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_read_streamer.md
MEM_READ_STREAMER -- requirements
Module: mem_read_streamer

Interface
REQ-001 Parameter DATA_WIDTH SHALL default to 256; memory and stream data width.
REQ-002 Parameter ADDR_WIDTH SHALL default to 16; memory word address width.
REQ-003 Parameter CNT_WIDTH SHALL default to 8; transfer length width.
REQ-004 Parameter FIFO_DEPTH SHALL default to 4; output buffer entries, power of two, at least 2.
REQ-005 Parameter TIMEOUT SHALL default to 64; maximum REQ cycles to wait for mem_ack.
REQ-006 Port clk, input, 1 bit, SHALL be the single clock; all logic samples on its rising edge.
REQ-007 Port reset_n, input, 1 bit, SHALL be the reset: synchronous, active-low.
REQ-008 Port start, input, 1 bit: one-cycle command pulse.
REQ-009 Port base_addr, input, ADDR_WIDTH: first word address, sampled with start.
REQ-010 Port count, input, CNT_WIDTH: number of words to read, sampled with start.
REQ-011 Port busy, output, 1 bit: transfer in progress.
REQ-012 Port done, output, 1 bit: one-cycle completion pulse.
REQ-013 Port err, output, 1 bit: ack timeout occurred; sticky until next accepted start.
REQ-014 Port mem_req, output, 1 bit: memory request, registered.
REQ-015 Port mem_ack, input, 1 bit: memory acknowledge pulse.
REQ-016 Port mem_w_en, output, 1 bit: write enable, constant 0 (read-only master).
REQ-017 Port mem_addr, output, ADDR_WIDTH: request address, registered.
REQ-018 Port mem_data, inout, DATA_WIDTH: never driven by this block (high-Z); read data is sampled on it.
REQ-019 Port out_valid, output, 1 bit; out_ready, input, 1 bit; out_data, output, DATA_WIDTH; out_last, output, 1 bit: valid/ready output stream.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, REQ, DRAIN and ERROR.
REQ-021 In IDLE, a start with count>0 SHALL latch base_addr and count, clear err, set busy and go to ISSUE; a start with count==0 SHALL pulse done on the next cycle and stay in IDLE.
REQ-022 A start outside IDLE SHALL be ignored.
REQ-023 In ISSUE, when (FIFO occupancy + 0) < FIFO_DEPTH, the block SHALL register mem_req=1 and mem_addr=current address, then go to REQ; otherwise it SHALL stay in ISSUE with mem_req=0.
REQ-024 mem_req and mem_addr SHALL remain stable throughout REQ.
REQ-025 mem_ack in the first REQ cycle SHALL be ignored as a protocol violation; mem_ack in any later REQ cycle SHALL push {mem_data, last} into the FIFO, deassert mem_req on the next edge, increment the address, and decrement the remaining count.
REQ-026 After each accepted mem_ack, the block SHALL go to DRAIN if the word was the last one, otherwise to ISSUE. This guarantees mem_req is low for at least one cycle between requests.
REQ-027 The address SHALL increment modulo 2^ADDR_WIDTH; 16'hFFFF SHALL be followed by 16'h0000.
REQ-028 The REQ cycle counter SHALL reset on entry to REQ. If it reaches TIMEOUT without an accepted mem_ack, the block SHALL drop mem_req, set err and go to ERROR.
REQ-029 The ERROR state SHALL flush the FIFO, pulse done for one cycle, clear busy and return to IDLE; err SHALL stay 1.
REQ-030 In DRAIN, the block SHALL wait until the FIFO is empty and the final beat has been accepted, then pulse done, clear busy and go to IDLE.
REQ-031 The FIFO SHALL present its head entry on out_data/out_last with out_valid=1 whenever it is non-empty; a beat SHALL transfer when out_valid and out_ready are both 1.
REQ-032 A FIFO push and pop in the same cycle SHALL leave the occupancy unchanged; overflow SHALL be impossible because of the space check in REQ-023.
REQ-033 out_last SHALL be 1 only on the beat carrying the count-th word.
REQ-034 out_data SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-035 When reset_n=0 at a clock edge, the block SHALL go to IDLE and set mem_req, busy, done, err, out_valid and out_last to 0, mem_addr to 0 and mem_w_en to 0, and empty the FIFO.
REQ-036 A reset in the middle of a transfer SHALL abandon it with no done pulse; the first request after reset SHALL come from a new start.

Verification
REQ-037 Basic: start, base=0x0010, count=3, slave acks 2 cycles after each req, out_ready=1 -> addresses 0x10/0x11/0x12 issued; 3 beats delivered, the third with out_last; one done pulse; err=0.
REQ-038 Back-pressure: count=8, out_ready=0 -> exactly 4 requests issued, then mem_req stays 0; releasing out_ready -> the remaining 4 requests follow; 8 beats delivered in order.
REQ-039 Wrap: base=0xFFFE, count=4 -> addresses FFFE, FFFF, 0000, 0001.
REQ-040 Timeout: slave never acks -> mem_req drops after 64 REQ cycles; err=1; one done pulse; FIFO empty; busy=0.
REQ-041 Edge cases: count=0 -> done one cycle after start with no mem_req; ack in the same cycle req rises -> ignored; start while busy -> ignored.
REQ-042 Reset in the middle of a transfer with reset_n=0 for one cycle -> all outputs at their reset values on the next cycle; no done pulse; protocol checks (ack is a pulse, no ack without req) hold for the whole run.
